// File: rtl/ex_hazard_ctrl.sv
// EX-stage pipeline sequencing controller: load-use stalls, branch/jump redirect
// flushes, data-memory wait stalls with a timeout watchdog, and a stall-cycle counter.

`ifndef LD
`define LD 7'b0000011
`endif

module ex_hazard_ctrl #(
    parameter int unsigned EXTRA_FLUSH = 0,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_ex_valid,
    input  logic [6:0]       i_ex_opcode,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_boj,
    input  logic             i_ex_jalr,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_stall_ex,
    output logic             o_stall_mem,
    output logic             o_bubble_ex,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic             o_pc_sel,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int unsigned FL_W  = 3;
    localparam int unsigned TMO_W = 16;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH,
        MEM_WAIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [FL_W-1:0]    fl_cnt;
    logic [FL_W-1:0]    fl_cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_cnt_nxt;
    logic               cnt_inc;

    logic mem_wait;
    logic redirect;
    logic load_use;

    // Hazard detection on the live pipeline-register fields
    assign mem_wait = i_mem_req & ~i_mem_ready;
    assign redirect = i_ex_valid & (i_ex_boj | i_ex_jalr);
    assign load_use = i_ex_valid && (i_ex_opcode == `LD) && (i_ex_rd_addr != 5'd0) && i_id_valid &&
                      ((i_id_use_rs1 && (i_id_rs1_addr == i_ex_rd_addr)) ||
                       (i_id_use_rs2 && (i_id_rs2_addr == i_ex_rd_addr)));

    // Next-state and stage-control decode
    always_comb begin
        state_nxt   = state;
        fl_cnt_nxt  = fl_cnt;
        tmo_cnt_nxt = tmo_cnt;
        cnt_inc     = 1'b0;
        o_stall_if  = 1'b0;
        o_stall_id  = 1'b0;
        o_stall_ex  = 1'b0;
        o_stall_mem = 1'b0;
        o_bubble_ex = 1'b0;
        o_flush_id  = 1'b0;
        o_flush_ex  = 1'b0;
        o_pc_sel    = 1'b0;
        o_mem_err   = 1'b0;

        case (state)
            INIT: begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
                o_flush_id = 1'b1;
                o_flush_ex = 1'b1;
                state_nxt  = RUN;
            end

            RUN: begin
                if (mem_wait) begin
                    o_stall_if  = 1'b1;
                    o_stall_id  = 1'b1;
                    o_stall_ex  = 1'b1;
                    o_stall_mem = 1'b1;
                    cnt_inc     = 1'b1;
                    tmo_cnt_nxt = '0;
                    state_nxt   = MEM_WAIT;
                end else if (redirect) begin
                    o_pc_sel   = 1'b1;
                    o_flush_id = 1'b1;
                    o_flush_ex = 1'b1;
                    if (EXTRA_FLUSH != 0) begin
                        fl_cnt_nxt = '0;
                        state_nxt  = FLUSH;
                    end
                end else if (load_use) begin
                    o_stall_if  = 1'b1;
                    o_stall_id  = 1'b1;
                    o_bubble_ex = 1'b1;
                    cnt_inc     = 1'b1;
                end
            end

            FLUSH: begin
                o_flush_id = 1'b1;
                o_flush_ex = 1'b1;
                if (fl_cnt == FL_W'(EXTRA_FLUSH - 1)) begin
                    fl_cnt_nxt = '0;
                    state_nxt  = RUN;
                end else begin
                    fl_cnt_nxt = fl_cnt + FL_W'(1);
                end
            end

            MEM_WAIT: begin
                if (i_mem_ready) begin
                    tmo_cnt_nxt = '0;
                    state_nxt   = RUN;
                end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
                    // Watchdog: give up on the access and let the pipe move
                    o_mem_err   = 1'b1;
                    tmo_cnt_nxt = '0;
                    state_nxt   = RUN;
                end else begin
                    o_stall_if  = 1'b1;
                    o_stall_id  = 1'b1;
                    o_stall_ex  = 1'b1;
                    o_stall_mem = 1'b1;
                    cnt_inc     = 1'b1;
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end

            default: state_nxt = INIT;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            fl_cnt      <= '0;
            tmo_cnt     <= '0;
            o_stall_cnt <= '0;
        end else begin
            state   <= state_nxt;
            fl_cnt  <= fl_cnt_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (cnt_inc && (o_stall_cnt != {CNT_W{1'b1}})) begin
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Randomized bench for ex_hazard_ctrl: two parameterizations share one stimulus
// stream and are checked every cycle against a behavioural sequencing model.

module tb_ex_hazard_ctrl;

    localparam int unsigned XF0 = 2;
    localparam int unsigned TO0 = 8;
    localparam int unsigned CW0 = 4;
    localparam int unsigned XF1 = 0;
    localparam int unsigned TO1 = 3;
    localparam int unsigned CW1 = 16;
    localparam logic [6:0]  OP_LD  = 7'b0000011;
    localparam logic [6:0]  OP_ALU = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic       ex_valid = 1'b0;
    logic [6:0] ex_opcode = '0;
    logic [4:0] ex_rd = '0;
    logic       ex_boj = 1'b0;
    logic       ex_jalr = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;

    logic a_sif, a_sid, a_sex, a_smem, a_bub, a_fid, a_fex, a_pc, a_err;
    logic b_sif, b_sid, b_sex, b_smem, b_bub, b_fid, b_fex, b_pc, b_err;
    logic [CW0-1:0] a_cnt;
    logic [CW1-1:0] b_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state, one slot per DUT
    bit m_init [2];
    int m_flush_left [2];
    bit m_waiting [2];
    int m_wait_n [2];
    int m_cnt [2];

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.EXTRA_FLUSH(XF0), .MEM_TIMEOUT(TO0), .CNT_W(CW0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_valid(ex_valid), .i_ex_opcode(ex_opcode), .i_ex_rd_addr(ex_rd),
        .i_ex_boj(ex_boj), .i_ex_jalr(ex_jalr),
        .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_stall_if(a_sif), .o_stall_id(a_sid), .o_stall_ex(a_sex), .o_stall_mem(a_smem),
        .o_bubble_ex(a_bub), .o_flush_id(a_fid), .o_flush_ex(a_fex), .o_pc_sel(a_pc),
        .o_mem_err(a_err), .o_stall_cnt(a_cnt)
    );

    ex_hazard_ctrl #(.EXTRA_FLUSH(XF1), .MEM_TIMEOUT(TO1), .CNT_W(CW1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_valid(ex_valid), .i_ex_opcode(ex_opcode), .i_ex_rd_addr(ex_rd),
        .i_ex_boj(ex_boj), .i_ex_jalr(ex_jalr),
        .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_stall_if(b_sif), .o_stall_id(b_sid), .o_stall_ex(b_sex), .o_stall_mem(b_smem),
        .o_bubble_ex(b_bub), .o_flush_id(b_fid), .o_flush_ex(b_fex), .o_pc_sel(b_pc),
        .o_mem_err(b_err), .o_stall_cnt(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {stall_if,stall_id,stall_ex,stall_mem,bubble_ex,flush_id,flush_ex,pc_sel,mem_err}
    // and pre-edge stall count for instance k; advances the model by one cycle.
    task automatic model_step(input int k, output logic [8:0] eo, output logic [31:0] ecnt);
        int unsigned xf  = (k == 0) ? XF0 : XF1;
        int unsigned to  = (k == 0) ? TO0 : TO1;
        int          max = (k == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1);
        bit stalled = 1'b0;
        bit lu;
        eo = '0;
        if (!rst_n) begin
            m_init[k] = 1'b1; m_flush_left[k] = 0; m_waiting[k] = 1'b0;
            m_wait_n[k] = 0; m_cnt[k] = 0;
        end
        ecnt = 32'(m_cnt[k]);
        lu = ex_valid && ex_opcode == OP_LD && ex_rd != 0 && id_valid &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (m_init[k]) begin
            eo = 9'b110001100;
            if (rst_n) m_init[k] = 1'b0;
        end else if (m_flush_left[k] > 0) begin
            eo = 9'b000001100;
            m_flush_left[k]--;
        end else if (m_waiting[k]) begin
            m_wait_n[k]++;
            if (mem_ready) m_waiting[k] = 1'b0;
            else if (m_wait_n[k] == int'(to)) begin
                eo = 9'b000000001;
                m_waiting[k] = 1'b0;
            end else begin
                eo = 9'b111100000;
                stalled = 1'b1;
            end
        end else if (mem_req && !mem_ready) begin
            eo = 9'b111100000;
            stalled = 1'b1;
            m_waiting[k] = 1'b1;
            m_wait_n[k] = 0;
        end else if (ex_valid && (ex_boj || ex_jalr)) begin
            eo = 9'b000001110;
            m_flush_left[k] = int'(xf);
        end else if (lu) begin
            eo = 9'b110010000;
            stalled = 1'b1;
        end
        if (stalled && m_cnt[k] < max) m_cnt[k]++;
    endtask

    initial begin
        logic [8:0]  eo;
        logic [31:0] ec;
        logic [8:0]  go;
        logic [31:0] gc;
        int stuck = 0;
        for (int k = 0; k < 2; k++) begin
            m_init[k] = 1'b1; m_flush_left[k] = 0; m_waiting[k] = 1'b0;
            m_wait_n[k] = 0; m_cnt[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_n = (cyc < 3) ? 1'b0 : (($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_opcode  = ($urandom_range(0, 1) != 0) ? OP_LD : OP_ALU;
            ex_rd      = 5'($urandom_range(0, 3));
            ex_boj     = ($urandom_range(0, 6) == 0);
            ex_jalr    = ($urandom_range(0, 15) == 0);
            // Occasional long not-ready bursts so the watchdogs fire
            if (stuck > 0) begin
                mem_req = 1'b1; mem_ready = 1'b0; stuck--;
            end else begin
                if ($urandom_range(0, 19) == 0) stuck = $urandom_range(4, 12);
                mem_req   = ($urandom_range(0, 2) == 0);
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                model_step(k, eo, ec);
                go = (k == 0) ? {a_sif, a_sid, a_sex, a_smem, a_bub, a_fid, a_fex, a_pc, a_err}
                              : {b_sif, b_sid, b_sex, b_smem, b_bub, b_fid, b_fex, b_pc, b_err};
                gc = (k == 0) ? 32'(a_cnt) : 32'(b_cnt);
                check_eq($sformatf("dut%0d cyc%0d ctrl", k, cyc), 32'(go), 32'(eo));
                check_eq($sformatf("dut%0d cyc%0d stall_cnt", k, cyc), gc, ec);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the EX stage of the 5-stage core. It detects load-use hazards, branch/jump redirects (EX boj/jalr) and data-memory wait states, and drives per-stage stall, flush and PC-select controls. It includes a memory timeout watchdog and a saturating stall-cycle counter. Sits beside EX; consumes ID/EX/MEM pipeline-register fields and feeds IF, ID/EX and EX/MEM register enables.

Parameters:
EXTRA_FLUSH, 0, additional flush cycles after the redirect cycle (0..7)
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before error (1..65535)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_id_valid  in  1  ID stage holds a valid instruction
i_id_rs1_addr  in  5  ID source 1
i_id_rs2_addr  in  5  ID source 2
i_id_use_rs1  in  1  ID instruction reads rs1
i_id_use_rs2  in  1  ID instruction reads rs2
i_ex_valid  in  1  EX holds a valid instruction
i_ex_opcode  in  7  EX opcode
i_ex_rd_addr  in  5  EX destination
i_ex_boj  in  1  EX branch taken / jump
i_ex_jalr  in  1  EX is jalr
i_mem_req  in  1  MEM stage has a load/store pending
i_mem_ready  in  1  data memory completes this cycle
o_stall_if  out  1  hold PC / IF register
o_stall_id  out  1  hold IF/ID register
o_stall_ex  out  1  hold ID/EX register
o_stall_mem  out  1  hold EX/MEM register
o_bubble_ex  out  1  load NOP into ID/EX
o_flush_id  out  1  clear IF/ID
o_flush_ex  out  1  clear ID/EX
o_pc_sel  out  1  1 = take EX redirect target
o_mem_err  out  1  one-cycle pulse on memory timeout
o_stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- FSM states: INIT, RUN, FLUSH, MEM_WAIT. State, flush counter, timeout counter and o_stall_cnt are registered; all other outputs are combinational from state and inputs.
- Reset (rst_n=0, asynchronous): state=INIT, counters=0, o_mem_err=0. In INIT: stall_if=stall_id=flush_id=flush_ex=1; all other outputs 0. INIT->RUN on the first clock edge with rst_n=1.
- Priority in RUN: memory wait > redirect > load-use.
- Memory wait: i_mem_req && !i_mem_ready. Assert all four stalls in the same cycle and go to MEM_WAIT. MEM_WAIT holds all stalls while i_mem_ready=0. The cycle with i_mem_ready=1 has no stall, and state returns to RUN. i_mem_req && i_mem_ready in RUN gives no stall.
- Timeout: the counter increments each MEM_WAIT cycle. If it reaches MEM_TIMEOUT with i_mem_ready still 0: pulse o_mem_err, release stalls, return to RUN, clear counter. The counter also clears on exit.
- Redirect: in RUN, i_ex_valid && (i_ex_boj || i_ex_jalr) with no memory wait. Assert o_pc_sel, o_flush_id and o_flush_ex for that cycle. If EXTRA_FLUSH>0, go to FLUSH. FLUSH asserts flush_id/flush_ex (pc_sel=0) for exactly EXTRA_FLUSH cycles, then returns to RUN.
- Redirects are evaluated only in RUN. A branch frozen in EX during MEM_WAIT is acted on in the first RUN cycle after release.
- Load-use: i_ex_valid && i_ex_opcode==`LD && i_ex_rd_addr!=0 && i_id_valid && ((i_id_use_rs1 && rs1==rd) || (i_id_use_rs2 && rs2==rd)). Assert stall_if, stall_id and bubble_ex for one cycle. State stays RUN; the next cycle re-evaluates with the NOP in EX, so the stall lasts exactly 1 cycle.
- Load-use simultaneous with a redirect: the redirect wins and there is no bubble. The x0 destination never hazards.
- o_stall_cnt increments by 1 on every cycle in which o_stall_if=1 in state RUN or MEM_WAIT (INIT excluded). It saturates at all-ones and is cleared only by reset.
- Reset mid-MEM_WAIT or mid-FLUSH: immediate return to INIT; counters cleared.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Required: INIT outputs (stall_if/id=1, flush_id/ex=1) during reset; RUN one edge after release; o_stall_cnt=0.
- Load-use: EX opcode=`LD, rd=5; ID rs2=5, use_rs2=1. Required: stall_if=stall_id=bubble_ex=1 for exactly 1 cycle; o_stall_cnt=1. The same with rd=0 gives no stall.
- Redirect: i_ex_boj=1, EXTRA_FLUSH=2. Required: pc_sel=1 for 1 cycle; flush_id/ex=1 for 3 consecutive cycles; then RUN. Adding a load-use match in the same cycle gives bubble_ex=0.
- Memory wait: i_mem_req=1, i_mem_ready=0 for 4 cycles, then 1. Required: all stalls=1 for 4 cycles, 0 on the ready cycle; o_stall_cnt +4. A branch held in EX redirects on the ready cycle+1.
- Timeout: MEM_TIMEOUT=8, ready never asserted. Required: o_mem_err pulses on the 8th MEM_WAIT cycle; stalls drop; state RUN.
- Saturation/reset-mid-op: CNT_W=4 with 20 stall cycles gives o_stall_cnt=15. Asserting rst_n=0 during MEM_WAIT gives immediate INIT with counter=0.
